// File: rtl/drp_reconf_seq.sv
// DRP master sequencer: holds a PLL in reset, read-modify-writes a table of
// {addr, mask, data} entries over the DRP port, releases reset and waits for lock.
module drp_reconf_seq #(
  parameter int TBL_DEPTH    = 16,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic        DCLK,
  input  logic        RST,
  input  logic        TBL_WE,
  input  logic [3:0]  TBL_WADDR,
  input  logic [38:0] TBL_WDATA,
  input  logic [4:0]  NUM_ENTRIES,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  output logic        PLL_RST,
  input  logic        LOCKED
);

  localparam int CNT_W = $clog2((LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] DRDY_LAST   = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [4:0]       MAX_ENTRIES = 5'(TBL_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_ISSUE  = 3'd1,
    S_RD_WAIT   = 3'd2,
    S_WR_ISSUE  = 3'd3,
    S_WR_WAIT   = 3'd4,
    S_LOCK_WAIT = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [4:0]       num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             den_q, den_d;
  logic             dwe_q, dwe_d;
  logic [6:0]       daddr_q, daddr_d;
  logic [15:0]      di_q, di_d;
  logic             pll_rst_q, pll_rst_d;

  logic [38:0]      tbl_q [TBL_DEPTH];
  logic [38:0]      ent_cur;
  logic [6:0]       first_addr;
  logic [6:0]       next_addr;
  logic [4:0]       num_sat;
  logic             last_entry;
  logic [15:0]      merged;

  // Table contents are deliberately not reset; writes are only taken while idle.
  always_ff @(posedge DCLK) begin
    if (TBL_WE && !busy_q) begin
      tbl_q[TBL_WADDR] <= TBL_WDATA;
    end
  end

  assign ent_cur    = tbl_q[idx_q];
  assign first_addr = tbl_q[4'd0][38:32];
  assign next_addr  = tbl_q[idx_q + 4'd1][38:32];
  assign num_sat    = (NUM_ENTRIES > MAX_ENTRIES) ? MAX_ENTRIES : NUM_ENTRIES;
  assign last_entry = ({1'b0, idx_q} == (num_q - 5'd1));
  // MASK bit set keeps the bit read back from the PLL; clear takes table DATA.
  assign merged     = (DO & ent_cur[31:16]) | (ent_cur[15:0] & ~ent_cur[31:16]);

  // DRP handshake: DEN is a one-cycle request (DWE qualifies it as a write);
  // DRDY completes it and is only looked at in the WAIT state that follows DEN.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    num_d     = num_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    den_d     = 1'b0;
    dwe_d     = 1'b0;
    daddr_d   = daddr_q;
    di_d      = di_q;
    pll_rst_d = pll_rst_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          num_d = num_sat;
          idx_d = 4'd0;
          err_d = 1'b0;
          if (num_sat == 5'd0) begin
            state_d = S_FINISH;
          end else begin
            state_d   = S_RD_ISSUE;
            pll_rst_d = 1'b1;
            den_d     = 1'b1;
            daddr_d   = first_addr;
          end
        end
      end

      S_RD_ISSUE: begin
        state_d = S_RD_WAIT;
        cnt_d   = '0;
      end

      S_RD_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (DRDY) begin
          state_d = S_WR_ISSUE;
          den_d   = 1'b1;
          dwe_d   = 1'b1;
          daddr_d = ent_cur[38:32];
          di_d    = merged;
        end else if (cnt_q == DRDY_LAST) begin
          state_d   = S_FINISH;
          err_d     = 1'b1;
          pll_rst_d = 1'b0;
        end
      end

      S_WR_ISSUE: begin
        state_d = S_WR_WAIT;
        cnt_d   = '0;
      end

      S_WR_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (DRDY) begin
          if (last_entry) begin
            state_d   = S_LOCK_WAIT;
            pll_rst_d = 1'b0;
            cnt_d     = '0;
          end else begin
            state_d = S_RD_ISSUE;
            idx_d   = idx_q + 4'd1;
            den_d   = 1'b1;
            daddr_d = next_addr;
          end
        end else if (cnt_q == DRDY_LAST) begin
          state_d   = S_FINISH;
          err_d     = 1'b1;
          pll_rst_d = 1'b0;
        end
      end

      S_LOCK_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (LOCKED) begin
          state_d = S_FINISH;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_FINISH;
          err_d   = 1'b1;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        pll_rst_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge DCLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      idx_q     <= 4'd0;
      num_q     <= 5'd0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      daddr_q   <= 7'd0;
      di_q      <= 16'd0;
      pll_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      den_q     <= den_d;
      dwe_q     <= dwe_d;
      daddr_q   <= daddr_d;
      di_q      <= di_d;
      pll_rst_q <= pll_rst_d;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR     = err_q;
  assign DEN     = den_q;
  assign DWE     = dwe_q;
  assign DADDR   = daddr_q;
  assign DI      = di_q;
  assign PLL_RST = pll_rst_q;

endmodule

// File: tb/tb_drp_reconf_seq.sv
// Directed bench for drp_reconf_seq: a DRP register model answering two cycles
// after DEN, a simple PLL lock model, a vector table and a few hand sequences.
module tb_drp_reconf_seq;

  logic        DCLK = 1'b0;
  logic        RST;
  logic        TBL_WE;
  logic [3:0]  TBL_WADDR;
  logic [38:0] TBL_WDATA;
  logic [4:0]  NUM_ENTRIES;
  logic        START;
  logic        BUSY, DONE, ERR;
  logic [6:0]  DADDR;
  logic        DEN, DWE;
  logic [15:0] DI;
  logic [15:0] DO = 16'h0;
  logic        DRDY = 1'b0;
  logic        PLL_RST;
  logic        LOCKED = 1'b0;

  drp_reconf_seq dut (
    .DCLK(DCLK), .RST(RST), .TBL_WE(TBL_WE), .TBL_WADDR(TBL_WADDR),
    .TBL_WDATA(TBL_WDATA), .NUM_ENTRIES(NUM_ENTRIES), .START(START),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .DADDR(DADDR), .DEN(DEN),
    .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY), .PLL_RST(PLL_RST),
    .LOCKED(LOCKED)
  );

  // clock / reset
  always #5 DCLK = ~DCLK;

  typedef struct {
    logic [4:0] num;
    bit         drdy_en;
    bit         lock_en;
    bit         disturb;
    int         exp_cyc;
    bit         exp_err;
  } vec_t;

  vec_t        vecs[8];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [6:0]  ent_addr[16];
  logic [15:0] ent_mask[16];
  logic [15:0] ent_data[16];
  logic [15:0] drp_mem[128];
  logic [15:0] exp_mem[128];
  logic [23:0] exp_q[$];
  bit          drdy_en = 1'b0;
  bit          lock_en = 1'b0;
  logic        s1 = 1'b0;
  logic        s2 = 1'b0;

  // DRP register model (DRDY two cycles after DEN) and PLL lock model.
  always @(negedge DCLK) begin
    DRDY = drdy_en & s2;
    s2   = s1;
    s1   = DEN;
    if (DEN && !DWE) DO = drp_mem[DADDR];
    if (DEN && DWE) drp_mem[DADDR] = DI;
    LOCKED = lock_en & !PLL_RST;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tbl_write(input int i);
    @(negedge DCLK);
    TBL_WE    = 1'b1;
    TBL_WADDR = 4'(i);
    TBL_WDATA = {ent_addr[i], ent_mask[i], ent_data[i]};
    @(negedge DCLK);
    TBL_WE    = 1'b0;
  endtask

  // scoreboard: expected DRP access list {dwe, addr, di-or-0}
  task automatic build_exp(input vec_t v);
    int n;
    logic [15:0] di;
    n = (v.num > 5'd16) ? 16 : int'(v.num);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b0, ent_addr[i], 16'h0});
      if (!v.drdy_en) break;
      di = (exp_mem[ent_addr[i]] & ent_mask[i]) | (ent_data[i] & ~ent_mask[i]);
      exp_q.push_back({1'b1, ent_addr[i], di});
      exp_mem[ent_addr[i]] = di;
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    logic [23:0] got[$];
    int cyc, pbad, dbad, seen, nchk;
    bit done_seen;
    drdy_en = v.drdy_en;
    lock_en = v.lock_en;
    build_exp(v);
    cyc = 0; pbad = 0; dbad = 0; seen = 0; done_seen = 1'b0;
    @(negedge DCLK);
    START       = 1'b1;
    NUM_ENTRIES = v.num;
    while (cyc < 1200 && !done_seen) begin
      @(negedge DCLK);
      cyc++;
      if (cyc == 1) begin
        START = 1'b0;
        chk($sformatf("v%0d_busy_first", k), 32'(BUSY), 32'd1);
        chk($sformatf("v%0d_err_cleared", k), 32'(ERR), 32'd0);
        chk($sformatf("v%0d_pll_rst_first", k), 32'(PLL_RST), 32'(v.num != 5'd0));
        chk($sformatf("v%0d_den_first", k), 32'(DEN), 32'(v.num != 5'd0));
        if (v.num != 5'd0) chk($sformatf("v%0d_daddr_first", k), 32'(DADDR), 32'(ent_addr[0]));
      end
      if (v.disturb && cyc == 3) begin
        START = 1'b1; NUM_ENTRIES = 5'd0;
        TBL_WE = 1'b1; TBL_WADDR = 4'd1; TBL_WDATA = {7'h55, 16'h0000, 16'h1234};
      end
      if (v.disturb && cyc == 4) begin
        START = 1'b0; TBL_WE = 1'b0;
      end
      if (DEN) begin
        got.push_back({DWE, DADDR, DWE ? DI : 16'h0});
        if (!PLL_RST) pbad++;
      end
      if (DWE && !DEN) dbad++;
      if (PLL_RST) seen++;
      if (DONE) done_seen = 1'b1;
    end
    chk($sformatf("v%0d_done_seen", k), 32'(done_seen), 32'd1);
    chk($sformatf("v%0d_done_cycle", k), 32'(cyc), 32'(v.exp_cyc));
    chk($sformatf("v%0d_err_at_done", k), 32'(ERR), 32'(v.exp_err));
    chk($sformatf("v%0d_pll_rst_at_done", k), 32'(PLL_RST), 32'd0);
    if (v.disturb) begin
      START = 1'b1; NUM_ENTRIES = 5'd1;
    end
    @(negedge DCLK);
    START = 1'b0;
    chk($sformatf("v%0d_busy_after", k), 32'(BUSY), 32'd0);
    chk($sformatf("v%0d_done_pulse", k), 32'(DONE), 32'd0);
    chk($sformatf("v%0d_err_sticky", k), 32'(ERR), 32'(v.exp_err));
    chk($sformatf("v%0d_access_count", k), 32'(got.size()), 32'(exp_q.size()));
    nchk = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < nchk; i++)
      chk($sformatf("v%0d_access%0d", k, i), 32'(got[i]), 32'(exp_q[i]));
    chk($sformatf("v%0d_pll_rst_during_den", k), 32'(pbad), 32'd0);
    chk($sformatf("v%0d_dwe_without_den", k), 32'(dbad), 32'd0);
    if (v.num == 5'd0) chk($sformatf("v%0d_pll_rst_never", k), 32'(seen), 32'd0);
  endtask

  initial begin
    int dn;
    for (int i = 0; i < 128; i++) begin
      drp_mem[i] = 16'hABCD ^ (16'(i) << 9);
      exp_mem[i] = drp_mem[i];
    end
    drp_mem[8] = 16'hABCD;
    exp_mem[8] = 16'hABCD;
    ent_addr[0] = 7'h08; ent_mask[0] = 16'hF000; ent_data[0] = 16'h0041;
    ent_addr[1] = 7'h09; ent_mask[1] = 16'h00FF; ent_data[1] = 16'h1200;
    ent_addr[2] = 7'h16; ent_mask[2] = 16'h0000; ent_data[2] = 16'hBEEF;
    for (int i = 3; i < 16; i++) begin
      ent_addr[i] = 7'(32 + i);
      ent_mask[i] = 16'h0F0F ^ 16'(i);
      ent_data[i] = 16'h1111 * 16'(i);
    end
    //          num    drdy  lock  dist  cyc   err
    vecs[0] = '{5'd1,  1'b1, 1'b1, 1'b0, 8,    1'b0};
    vecs[1] = '{5'd3,  1'b1, 1'b1, 1'b0, 20,   1'b0};
    vecs[2] = '{5'd1,  1'b0, 1'b1, 1'b0, 66,   1'b1};
    vecs[3] = '{5'd1,  1'b1, 1'b0, 1'b0, 1031, 1'b1};
    vecs[4] = '{5'd1,  1'b1, 1'b1, 1'b0, 8,    1'b0};
    vecs[5] = '{5'd0,  1'b1, 1'b1, 1'b0, 1,    1'b0};
    vecs[6] = '{5'd20, 1'b1, 1'b1, 1'b0, 98,   1'b0};
    vecs[7] = '{5'd3,  1'b1, 1'b1, 1'b1, 20,   1'b0};

    RST = 1'b1; TBL_WE = 1'b0; TBL_WADDR = 4'd0; TBL_WDATA = '0;
    NUM_ENTRIES = 5'd0; START = 1'b0;
    repeat (3) @(negedge DCLK);
    RST = 1'b0;
    @(negedge DCLK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_den", 32'(DEN), 32'd0);
    chk("rst_dwe", 32'(DWE), 32'd0);
    chk("rst_daddr", 32'(DADDR), 32'd0);
    chk("rst_di", 32'(DI), 32'd0);
    chk("rst_pll_rst", 32'(PLL_RST), 32'd0);

    for (int i = 0; i < 16; i++) tbl_write(i);

    for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

    // synchronous reset in the middle of RD_WAIT
    drdy_en = 1'b0;
    lock_en = 1'b1;
    @(negedge DCLK);
    START = 1'b1; NUM_ENTRIES = 5'd1;
    @(negedge DCLK);
    START = 1'b0;
    repeat (2) @(negedge DCLK);
    chk("rstmid_busy_before", 32'(BUSY), 32'd1);
    chk("rstmid_pll_rst_before", 32'(PLL_RST), 32'd1);
    RST = 1'b1;
    @(negedge DCLK);
    RST = 1'b0;
    chk("rstmid_busy", 32'(BUSY), 32'd0);
    chk("rstmid_den", 32'(DEN), 32'd0);
    chk("rstmid_pll_rst", 32'(PLL_RST), 32'd0);
    chk("rstmid_done", 32'(DONE), 32'd0);
    dn = 0;
    repeat (5) begin
      @(negedge DCLK);
      if (DONE || BUSY) dn++;
    end
    chk("rstmid_quiet_after", 32'(dn), 32'd0);

    run_vec(8, vecs[4]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
